// File: rtl/axi_pattern_checker.sv
//------------------------------------------------------------------------------
// Module      : axi_pattern_checker
// Description : AXI read master that reads back a SEED+k incrementing pattern
//               and reports pass/fail, error count and first failing address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi_pattern_checker #(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter int          BURST_LEN  = 16,
  parameter int          NUM_BURSTS = 4,
  parameter logic [31:0] SEED       = 32'h1234_5678
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trigger,
  // AXI read address channel
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic [3:0]  m_arid,
  output logic [3:0]  m_arcache,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  // AXI read data channel
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  output logic        m_rready,
  // AXI write channels, permanently idle
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic [3:0]  m_awid,
  output logic        m_awvalid,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  output logic        m_bready,
  // status
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_addr
);

  localparam int BW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;

  localparam logic [1:0]    c_st_idle    = 2'd0;
  localparam logic [1:0]    c_st_addr    = 2'd1;
  localparam logic [1:0]    c_st_data    = 2'd2;
  localparam logic [1:0]    c_st_done    = 2'd3;
  localparam logic [BW-1:0] c_last_burst = BW'(NUM_BURSTS - 1);
  localparam logic [3:0]    c_last_beat  = 4'(BURST_LEN - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [BW-1:0] r_burst;
  logic [3:0]    r_beat;
  logic [31:0]   r_k;
  logic [31:0]   w_burst_base;
  logic          w_beat_hs;
  logic          w_last_pos;
  logic          w_beat_bad;
  logic          w_burst_end;

  assign w_burst_base = BASE_ADDR + 32'(r_burst) * 32'(BURST_LEN * 4);
  assign w_beat_hs    = (r_state == c_st_data) && m_rvalid;
  assign w_last_pos   = (r_beat == c_last_beat);
  assign w_beat_bad   = (m_rdata != SEED + r_k) || (m_rresp != 2'b00) || (m_rlast != w_last_pos);
  // A burst closes on rlast or on the nominal last beat, whichever comes first.
  assign w_burst_end  = w_beat_hs && (m_rlast || w_last_pos);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (trigger)     w_state_nxt = c_st_addr;
      c_st_addr: if (m_arready)   w_state_nxt = c_st_data;
      c_st_data: if (w_burst_end) w_state_nxt = (r_burst == c_last_burst) ? c_st_done : c_st_addr;
      default:                    w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    m_arvalid = (r_state == c_st_addr);
    m_rready  = (r_state == c_st_data);
    busy      = (r_state == c_st_addr) || (r_state == c_st_data);
    done      = (r_state == c_st_done);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_burst        <= '0;
      r_beat         <= '0;
      r_k            <= '0;
      err_count      <= '0;
      first_err_addr <= '0;
      pass           <= 1'b0;
    end else if (r_state == c_st_idle) begin
      if (trigger) begin
        r_burst        <= '0;
        r_beat         <= '0;
        r_k            <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end
    end else if (w_beat_hs) begin
      r_k    <= r_k + 32'd1;
      r_beat <= w_burst_end ? 4'd0 : r_beat + 4'd1;
      if (w_beat_bad) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (err_count == 16'd0)    first_err_addr <= w_burst_base + 32'({r_beat, 2'b00});
      end
      if (w_burst_end) begin
        if (r_burst != c_last_burst) r_burst <= r_burst + 1'b1;
        else                         pass    <= (err_count == 16'd0) && !w_beat_bad;
      end
    end
  end

  assign m_araddr  = w_burst_base;
  assign m_arlen   = 8'(BURST_LEN - 1);
  assign m_arsize  = 3'b010;
  assign m_arburst = 2'b01;
  assign m_arid    = 4'd0;
  assign m_arcache = 4'd0;
  assign m_arprot  = 3'd0;

  assign m_awaddr  = 32'd0;
  assign m_awlen   = 8'd0;
  assign m_awsize  = 3'b010;
  assign m_awburst = 2'b01;
  assign m_awid    = 4'd0;
  assign m_awvalid = 1'b0;
  assign m_wdata   = 32'd0;
  assign m_wstrb   = 4'd0;
  assign m_wlast   = 1'b0;
  assign m_wvalid  = 1'b0;
  assign m_bready  = 1'b1;

endmodule

`default_nettype wire

// File: tb/tb_axi_pattern_checker.sv
//------------------------------------------------------------------------------
// Module      : tb_axi_pattern_checker
// Description : Self-checking bench for axi_pattern_checker with a behavioural
//               AXI read slave and a beat-log reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_axi_pattern_checker;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          BL    = 16;
  localparam int          NB    = 4;
  localparam logic [31:0] SEED  = 32'h1234_5678;
  localparam int          TOTAL = BL * NB;

  logic clk = 1'b0, rstn = 1'b1, trigger = 1'b0;
  logic [31:0] m_araddr;  logic [7:0] m_arlen;  logic [2:0] m_arsize;  logic [1:0] m_arburst;
  logic [3:0]  m_arid, m_arcache;  logic [2:0] m_arprot;  logic m_arvalid;  logic m_arready = 1'b0;
  logic m_rvalid = 1'b0;  logic [31:0] m_rdata = '0;  logic [1:0] m_rresp = '0;  logic m_rlast = 1'b0;
  logic m_rready;
  logic [31:0] m_awaddr, m_wdata;  logic [7:0] m_awlen;  logic [2:0] m_awsize;  logic [1:0] m_awburst;
  logic [3:0]  m_awid, m_wstrb;  logic m_awvalid, m_wlast, m_wvalid, m_bready;
  logic busy, done, pass;  logic [15:0] err_count;  logic [31:0] first_err_addr;

  axi_pattern_checker #(.BASE_ADDR(BASE), .BURST_LEN(BL), .NUM_BURSTS(NB), .SEED(SEED)) dut (
    .clk(clk), .rstn(rstn), .trigger(trigger),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arid(m_arid), .m_arcache(m_arcache), .m_arprot(m_arprot), .m_arvalid(m_arvalid),
    .m_arready(m_arready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rlast(m_rlast), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awid(m_awid), .m_awvalid(m_awvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_bready(m_bready),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .first_err_addr(first_err_addr));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // slave memory, configuration and logs
  logic [31:0] mem [0:TOTAL-1];
  int ar_delay = 0, gap_pct = 0, slverr_idx = -1, early_burst = -1, early_len = BL;
  logic [31:0] ar_log[$];
  logic [31:0] lg_data[$];
  logic [1:0]  lg_resp[$];
  logic        lg_last[$];
  int done_cnt = 0, done_cyc = 0, last_hs_cyc = 0, stab_viol = 0;
  int pend = 0, s_idx = 0, s_n = BL, s_gidx = 0, ar_wait = 0;
  logic [31:0] s_addr = '0;

  // AXI read slave: samples handshakes at negedge, updates just after posedge
  always begin : slave
    logic ar_hs, r_hs, r_last, prev_arv, prev_hs;
    logic [31:0] ar_a, r_d, prev_addr;
    logic [1:0] r_r;
    prev_arv = 1'b0; prev_hs = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      ar_hs = m_arvalid && m_arready;  ar_a = m_araddr;
      r_hs  = m_rvalid && m_rready;    r_d = m_rdata;  r_r = m_rresp;  r_last = m_rlast;
      if (!rstn) prev_arv = 1'b0;
      else begin
        if (prev_arv && !prev_hs && (!m_arvalid || m_araddr !== prev_addr)) stab_viol++;
        prev_arv = m_arvalid; prev_addr = m_araddr; prev_hs = ar_hs;
      end
      if (done === 1'b1) begin done_cnt++; done_cyc = cyc; end
      @(posedge clk); #1;
      if (!rstn) begin
        pend = 0; ar_wait = 0; m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0;
      end else begin
        if (ar_hs) begin
          ar_log.push_back(ar_a);
          pend = 1; s_idx = 0; s_addr = ar_a; ar_wait = 0;
          s_n = (early_burst == ar_log.size() - 1) ? early_len : BL;
        end
        if (r_hs) begin
          lg_data.push_back(r_d); lg_resp.push_back(r_r); lg_last.push_back(r_last);
          s_gidx++; last_hs_cyc = cyc;
          if (r_last) pend = 0; else s_idx++;
        end
        if (m_arvalid && pend == 0 && !ar_hs) begin
          if (ar_wait >= ar_delay) m_arready = 1'b1;
          else begin ar_wait++; m_arready = 1'b0; end
        end else m_arready = 1'b0;
        if (m_rvalid && !r_hs) begin
          // hold the pending beat unchanged until accepted
        end else if (pend != 0 && int'($urandom_range(99)) >= gap_pct) begin
          m_rvalid = 1'b1;
          m_rdata  = mem[int'(s_addr >> 2) + s_idx];
          m_rresp  = (s_gidx == slverr_idx) ? 2'b10 : 2'b00;
          m_rlast  = (s_idx == s_n - 1);
        end else begin
          m_rvalid = 1'b0; m_rlast = 1'b0;
        end
      end
    end
  end

  // Reference: walk the accepted-beat stream; expected data is SEED + run index,
  // bursts end at rlast or at beat BL-1, rlast must coincide with beat BL-1.
  task automatic model(output int cnt, output logic [31:0] first);
    int b, p; logic [31:0] expv; bit bad;
    b = 0; p = 0; cnt = 0; first = '0;
    for (int j = 0; j < lg_data.size(); j++) begin
      expv = SEED + 32'(j);
      bad  = (lg_data[j] !== expv) || (lg_resp[j] !== 2'b00) || (lg_last[j] !== (p == BL - 1));
      if (bad) begin
        if (cnt == 0) first = BASE + 32'((b * BL + p) * 4);
        if (cnt < 65535) cnt++;
      end
      if (lg_last[j] || p == BL - 1) begin b++; p = 0; end else p++;
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < TOTAL; i++) mem[i] = SEED + 32'(i);
  endtask

  task automatic start_run();
    @(negedge clk);
    ar_log.delete(); lg_data.delete(); lg_resp.delete(); lg_last.delete(); s_gidx = 0;
    trigger = 1'b1;
    @(posedge clk); #1;
    trigger = 1'b0;
    chk("ar_latency", m_arvalid, 1'b1);
    chk("busy_rise", busy, 1'b1);
    chk("araddr_first", m_araddr, BASE);
    chk("ar_fields", {m_arlen, m_arsize, m_arburst, m_arid}, {8'(BL - 1), 3'b010, 2'b01, 4'd0});
  endtask

  task automatic finish_run(input string tag, input int retrig_at);
    int d0, i, mcnt, nbeats; logic [31:0] mfirst;
    d0 = done_cnt - ((done === 1'b1) ? 1 : 0);
    i = 0;
    while (done_cnt == d0 && i < 3000) begin
      @(negedge clk);
      trigger = (i == retrig_at);
      i++;
    end
    trigger = 1'b0;
    chk({tag, "_done_seen"}, 32'(done_cnt != d0), 32'd1);
    repeat (4) @(negedge clk);
    model(mcnt, mfirst);
    nbeats = (early_burst >= 0) ? (NB - 1) * BL + early_len : TOTAL;
    chk({tag, "_single_done"}, 32'(done_cnt - d0), 32'd1);
    chk({tag, "_done_latency"}, 32'(done_cyc), 32'(last_hs_cyc));
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_beats"}, 32'(lg_data.size()), 32'(nbeats));
    chk({tag, "_err_count"}, 32'(err_count), 32'(mcnt));
    chk({tag, "_first_err"}, first_err_addr, mfirst);
    chk({tag, "_pass"}, pass, (mcnt == 0));
    chk({tag, "_ar_count"}, 32'(ar_log.size()), 32'(NB));
    for (int n = 0; n < NB && n < ar_log.size(); n++)
      chk({tag, "_ar_addr"}, ar_log[n], BASE + 32'(n * BL * 4));
    chk({tag, "_ar_stable"}, 32'(stab_viol), 32'd0);
  endtask

  initial begin
    int nc, waited;
    fill_mem();
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_pass", pass, 1'b0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_first", first_err_addr, 32'd0);
    chk("rst_arvalid", m_arvalid, 1'b0);
    chk("rst_rready", m_rready, 1'b0);
    chk("wr_tieoff", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // clean run
    start_run(); finish_run("clean", -1);
    chk("clean_pass_direct", pass, 1'b1);

    // corrupted word at 0x44
    mem[17] = mem[17] ^ 32'h0000_0100;
    start_run(); finish_run("corrupt", -1);
    chk("corrupt_cnt_direct", 32'(err_count), 32'd1);
    chk("corrupt_addr_direct", first_err_addr, 32'h44);
    fill_mem();

    // slow arready
    ar_delay = 7;
    start_run(); finish_run("ar_stall", -1);
    ar_delay = 0;

    // random rvalid gaps plus one SLVERR beat
    gap_pct = 40; slverr_idx = int'($urandom_range(TOTAL - 1));
    start_run(); finish_run("slverr", -1);
    chk("slverr_cnt_direct", 32'(err_count), 32'd1);
    slverr_idx = -1;

    // retrigger while busy is ignored; counters cleared after previous failing run
    start_run(); finish_run("retrig", 20);
    chk("retrig_pass_direct", pass, 1'b1);
    gap_pct = 0;

    // early rlast in burst 1
    early_burst = 1; early_len = 11;
    start_run(); finish_run("early_last", -1);
    chk("early_first_direct", first_err_addr, BASE + 32'((BL + 10) * 4));
    early_burst = -1; early_len = BL;

    // reset during burst 2
    gap_pct = 20;
    start_run();
    waited = 0;
    while (!(ar_log.size() >= 3 && lg_data.size() >= 2 * BL + 3) && waited < 2000) begin
      @(negedge clk); waited++;
    end
    chk("midrst_reached", 32'(waited < 2000), 32'd1);
    @(negedge clk); #2 rstn = 1'b0;
    #1;
    chk("midrst_arvalid", m_arvalid, 1'b0);
    chk("midrst_rready", m_rready, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_err", 32'(err_count), 32'd0);
    repeat (3) @(negedge clk);
    #2 rstn = 1'b1;
    start_run(); finish_run("post_rst", -1);
    chk("post_rst_pass_direct", pass, 1'b1);

    // randomized runs
    for (int r = 0; r < 4; r++) begin
      fill_mem();
      nc = int'($urandom_range(3));
      for (int c = 0; c < nc; c++) begin
        int idx;
        idx = int'($urandom_range(TOTAL - 1));
        mem[idx] = mem[idx] ^ (32'h1 << $urandom_range(31));
      end
      gap_pct    = int'($urandom_range(60));
      ar_delay   = int'($urandom_range(4));
      slverr_idx = ($urandom_range(1) == 1) ? int'($urandom_range(TOTAL - 1)) : -1;
      start_run(); finish_run("random", -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
